// File: rtl/fir_csm_pkg.sv
// rtl/fir_csm_pkg.sv - shared constants for the computation-sharing-multiplier FIR datapath
package fir_csm_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OUT_W_DEF  = 16;
    localparam int NUM_ODD    = 8;

endpackage

// File: rtl/elastic_slice.sv
// rtl/elastic_slice.sv - valid/ready register slice with synchronous flush
module elastic_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic load;

    // The slot frees up either when empty or when its contents leave this cycle.
    assign in_ready = !out_valid | out_ready;
    // Flush blocks loading so the data registers keep their previous contents.
    assign load     = in_valid & in_ready & !flush;

    // Occupancy: flush empties, a load fills, a consume without reload empties.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload register changes only when the slice loads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/odd_multiple_precomputer.sv
// rtl/odd_multiple_precomputer.sv - two-stage pipeline producing x1..x15 odd multiples
module odd_multiple_precomputer
    import fir_csm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  x1,
    output logic [OUT_W-1:0]  x3,
    output logic [OUT_W-1:0]  x5,
    output logic [OUT_W-1:0]  x7,
    output logic [OUT_W-1:0]  x9,
    output logic [OUT_W-1:0]  x11,
    output logic [OUT_W-1:0]  x13,
    output logic [OUT_W-1:0]  x15
);

    localparam int A_W = 6 * OUT_W;
    localparam int B_W = NUM_ODD * OUT_W;

    logic [OUT_W-1:0] xe;
    logic [OUT_W-1:0] m2, m4, m8;
    logic [A_W-1:0]   a_in, a_data;
    logic [B_W-1:0]   b_in, b_data;
    logic             a_ready, a_valid, b_ready;
    logic [OUT_W-1:0] a_x1, a_x3, a_x5, a_x7, a_x9, a_x8;

    // Sign-extend first so every shift/add below is exact at OUT_W bits.
    assign xe = {{(OUT_W-DATA_W){x[DATA_W-1]}}, x};
    assign m2 = xe << 1;
    assign m4 = xe << 2;
    assign m8 = xe << 3;

    assign a_in = {m8, xe + m8, m8 - xe, xe + m4, xe + m2, xe};

    assign in_ready = a_ready & !flush;

    elastic_slice #(.W(A_W)) u_stage_a (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (a_ready),
        .in_data   (a_in),
        .out_valid (a_valid),
        .out_ready (b_ready),
        .out_data  (a_data)
    );

    assign a_x1 = a_data[0*OUT_W +: OUT_W];
    assign a_x3 = a_data[1*OUT_W +: OUT_W];
    assign a_x5 = a_data[2*OUT_W +: OUT_W];
    assign a_x7 = a_data[3*OUT_W +: OUT_W];
    assign a_x9 = a_data[4*OUT_W +: OUT_W];
    assign a_x8 = a_data[5*OUT_W +: OUT_W];

    // The upper three multiples reuse 8x from stage A: 11=3+8, 13=5+8, 15=7+8.
    assign b_in = {a_x7 + a_x8, a_x5 + a_x8, a_x3 + a_x8, a_x9, a_x7, a_x5, a_x3, a_x1};

    elastic_slice #(.W(B_W)) u_stage_b (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (a_valid),
        .in_ready  (b_ready),
        .in_data   (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (b_data)
    );

    assign x1  = b_data[0*OUT_W +: OUT_W];
    assign x3  = b_data[1*OUT_W +: OUT_W];
    assign x5  = b_data[2*OUT_W +: OUT_W];
    assign x7  = b_data[3*OUT_W +: OUT_W];
    assign x9  = b_data[4*OUT_W +: OUT_W];
    assign x11 = b_data[5*OUT_W +: OUT_W];
    assign x13 = b_data[6*OUT_W +: OUT_W];
    assign x15 = b_data[7*OUT_W +: OUT_W];

endmodule

// File: tb/tb_odd_multiple_precomputer.sv
// tb/tb_odd_multiple_precomputer.sv - self-checking bench for odd_multiple_precomputer
module tb_odd_multiple_precomputer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  x = 8'd0;
    logic        in_ready, out_valid;
    logic [15:0] x1, x3, x5, x7, x9, x11, x13, x15;
    logic [15:0] outs [8];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    odd_multiple_precomputer dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x1        (x1),
        .x3        (x3),
        .x5        (x5),
        .x7        (x7),
        .x9        (x9),
        .x11       (x11),
        .x13       (x13),
        .x15       (x15)
    );

    always_comb begin
        outs[0] = x1;  outs[1] = x3;  outs[2] = x5;  outs[3] = x7;
        outs[4] = x9;  outs[5] = x11; outs[6] = x13; outs[7] = x15;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of accepted samples with the edge index of acceptance.
    // A sample becomes visible one edge after it was accepted if it is the oldest.
    int q[$];
    int qe[$];
    int cyc = 0;

    function automatic bit m_out_valid();
        return (q.size() > 0) && (cyc >= qe[0] + 1);
    endfunction

    function automatic bit m_in_ready();
        return !flush && ((q.size() < 2) || out_ready);
    endfunction

    always @(posedge clk) begin
        if (resetn) begin
            bit acc, emit;
            acc  = in_valid && m_in_ready();
            emit = m_out_valid() && out_ready;
            cyc++;
            if (emit) begin
                void'(q.pop_front());
                void'(qe.pop_front());
            end
            if (flush) begin
                q.delete();
                qe.delete();
            end else if (acc) begin
                q.push_back(int'($signed(x)));
                qe.push_back(cyc);
            end
        end
    end

    always @(negedge resetn) begin
        q.delete();
        qe.delete();
    end

    always @(negedge clk) begin
        check("model_out_valid", {31'd0, out_valid}, {31'd0, m_out_valid()});
        check("model_in_ready", {31'd0, in_ready}, {31'd0, m_in_ready()});
        if (m_out_valid()) begin
            for (int k = 0; k < 8; k++) begin
                logic [15:0] e;
                e = 16'((2 * k + 1) * q[0]);
                check($sformatf("model_x%0d", 2 * k + 1), {16'd0, outs[k]}, {16'd0, e});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present v until accepted; returns one time unit after the negedge following acceptance.
    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        x = v;
        while (1) begin
            #1;
            if (in_ready) begin
                step();
                break;
            end
            step();
            n++;
            if (n > 50) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;

        // reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 8; k++) check($sformatf("rst_out%0d", k), {16'd0, outs[k]}, 32'd0);

        // single sample, latency 2
        out_ready = 1'b1;
        send(8'd5);
        check("lat_early", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("x5_x1", {16'd0, x1}, 32'd5);
        check("x5_x3", {16'd0, x3}, 32'd15);
        check("x5_x5", {16'd0, x5}, 32'd25);
        check("x5_x7", {16'd0, x7}, 32'd35);
        check("x5_x9", {16'd0, x9}, 32'd45);
        check("x5_x11", {16'd0, x11}, 32'd55);
        check("x5_x13", {16'd0, x13}, 32'd65);
        check("x5_x15", {16'd0, x15}, 32'd75);
        step();
        check("single_drop", {31'd0, out_valid}, 32'd0);

        // extremes
        send(8'h80);
        step();
        check("neg_x15", {16'd0, x15}, 32'h0000F880);
        check("neg_x1", {16'd0, x1}, 32'h0000FF80);
        check("neg_x7", {16'd0, x7}, 32'h0000FC80);
        step();
        send(8'h7F);
        step();
        check("pos_x15", {16'd0, x15}, 32'h00000771);
        check("pos_x11", {16'd0, x11}, 32'h00000575);
        step();
        send(8'h00);
        step();
        for (int k = 0; k < 8; k++) check($sformatf("zero_out%0d", k), {16'd0, outs[k]}, 32'd0);
        step();

        // streaming 1..20
        for (int v = 1; v <= 20; v++) send(8'(v));
        check("stream_tail", {16'd0, x15}, 32'd285);
        step();
        check("stream_last", {16'd0, x15}, 32'd300);
        step();
        step();

        // backpressure
        out_ready = 1'b0;
        send(8'd10);
        send(8'd11);
        in_valid = 1'b1;
        x = 8'd12;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_x1", {16'd0, x1}, 32'd10);
            step();
        end
        out_ready = 1'b1;
        send(8'd12);
        check("bp_order_11", {16'd0, x1}, 32'd11);
        step();
        check("bp_order_12", {16'd0, x1}, 32'd12);
        step();
        check("bp_drain", {31'd0, out_valid}, 32'd0);

        // flush
        send(8'd7);
        flush = 1'b1;
        in_valid = 1'b1;
        x = 8'd9;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_no_out", {31'd0, out_valid}, 32'd0);
            step();
        end
        send(8'd3);
        check("flush_lat_early", {31'd0, out_valid}, 32'd0);
        step();
        check("flush_lat_valid", {31'd0, out_valid}, 32'd1);
        check("flush_x15", {16'd0, x15}, 32'd45);
        step();

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        send(8'd1);
        send(8'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_x1", {16'd0, x1}, 32'd0);
        check("arst_x15", {16'd0, x15}, 32'd0);
        step();
        step();
        resetn = 1'b1;
        out_ready = 1'b1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        send(8'd4);
        step();
        check("arst_resume_valid", {31'd0, out_valid}, 32'd1);
        check("arst_resume_x9", {16'd0, x9}, 32'd36);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
